// File: rtl/core_irq_pkg.sv
// Shared types and default vector addresses for the 6502-compatible interrupt arbiter.
// Source encoding doubles as the arbitration result carried between comb and seq logic.
package core_irq_pkg;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IRQ,
    SRC_NMI,
    SRC_RESET
  } irq_src_t;

  localparam logic [15:0] DEF_NMI_VECTOR   = 16'hFFFA;
  localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;
  localparam int          DEF_SYNC_STAGES  = 2;

  // Software BRK and the idle case share the IRQ vector, so only NMI and RESET differ.
  function automatic logic [15:0] vecFor(
    input irq_src_t    src,
    input logic [15:0] nmiVec,
    input logic [15:0] rstVec,
    input logic [15:0] irqVec
  );
    logic [15:0] vec;
    vec = irqVec;
    if (src == SRC_NMI)   vec = nmiVec;
    if (src == SRC_RESET) vec = rstVec;
    return vec;
  endfunction

endpackage

// File: rtl/core_irq_sync.sv
// Multi-flop synchroniser for an active-low asynchronous request line, with a
// falling-edge strobe that is valid for exactly one clock at the synchronised output.
module core_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Chain and history both idle high so a line held low through reset still
  // produces an edge when first seen afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign fall = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt arbiter: latches RESET/NMI, samples IRQ and, at each opcode-fetch boundary,
// picks what the core vectors to, holding the result until the next boundary.
module core_irq_ctrl
  import core_irq_pkg::*;
#(
  parameter logic [15:0] NMI_VECTOR   = DEF_NMI_VECTOR,
  parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR,
  parameter int          SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_enable,
  input  logic        I_nmi,
  input  logic        I_irq,
  input  logic        I_irq_mask,
  output logic        O_force_brk,
  output logic        O_irq_mask,
  output logic [15:0] O_vec_addr_lo,
  output logic [15:0] O_vec_addr_hi
);

  logic     nmiSync;
  logic     nmiFall;
  logic     irqSync;
  logic     irqFall_unused;

  logic     rstPend_q,  rstPend_d;
  logic     nmiPend_q,  nmiPend_d;
  logic     forceBrk_q, forceBrk_d;
  logic     irqMask_q,  irqMask_d;
  logic [15:0] vecLo_q, vecLo_d;
  logic [15:0] vecHi_q, vecHi_d;
  irq_src_t sel;

  core_irq_sync #(.STAGES(SYNC_STAGES)) uNmiSync (
    .clk  (I_clock),
    .rst  (I_reset),
    .d    (I_nmi),
    .q    (nmiSync),
    .fall (nmiFall)
  );

  core_irq_sync #(.STAGES(SYNC_STAGES)) uIrqSync (
    .clk  (I_clock),
    .rst  (I_reset),
    .d    (I_irq),
    .q    (irqSync),
    .fall (irqFall_unused)
  );

  // An NMI edge seen this very cycle competes as if already pending, so a
  // boundary coinciding with the edge is not delayed by one instruction.
  always_comb begin
    sel = SRC_NONE;
    if (I_enable) begin
      if (rstPend_q)                     sel = SRC_RESET;
      else if (nmiPend_q || nmiFall)     sel = SRC_NMI;
      else if (!irqSync && !I_irq_mask)  sel = SRC_IRQ;
      else                               sel = SRC_NONE;
    end
  end

  always_comb begin
    rstPend_d  = rstPend_q && (sel != SRC_RESET);
    nmiPend_d  = (nmiPend_q || nmiFall) && (sel != SRC_NMI);
    forceBrk_d = forceBrk_q;
    irqMask_d  = irqMask_q;
    vecLo_d    = vecLo_q;
    vecHi_d    = vecHi_q;
    if (I_enable) begin
      forceBrk_d = (sel != SRC_NONE);
      irqMask_d  = (sel != SRC_NONE);
      vecLo_d    = vecFor(sel, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR);
      vecHi_d    = vecFor(sel, NMI_VECTOR, RESET_VECTOR, IRQ_VECTOR) + 16'd1;
    end
  end

  // Reset dominates a simultaneous boundary and drops any NMI already latched.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      rstPend_q  <= 1'b1;
      nmiPend_q  <= 1'b0;
      forceBrk_q <= 1'b1;
      irqMask_q  <= 1'b1;
      vecLo_q    <= RESET_VECTOR;
      vecHi_q    <= RESET_VECTOR + 16'd1;
    end else begin
      rstPend_q  <= rstPend_d;
      nmiPend_q  <= nmiPend_d;
      forceBrk_q <= forceBrk_d;
      irqMask_q  <= irqMask_d;
      vecLo_q    <= vecLo_d;
      vecHi_q    <= vecHi_d;
    end
  end

  assign O_force_brk   = forceBrk_q;
  assign O_irq_mask    = irqMask_q;
  assign O_vec_addr_lo = vecLo_q;
  assign O_vec_addr_hi = vecHi_q;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Scoreboard bench for core_irq_ctrl: enable pulses queue hand-computed results,
// a negedge monitor checks them plus reset values and hold behaviour between enables.
module tb_core_irq_ctrl;

  logic        I_clock    = 1'b0;
  logic        I_reset    = 1'b1;
  logic        I_enable   = 1'b0;
  logic        I_nmi      = 1'b1;
  logic        I_irq      = 1'b1;
  logic        I_irq_mask = 1'b0;
  logic        O_force_brk;
  logic        O_irq_mask;
  logic [15:0] O_vec_addr_lo;
  logic [15:0] O_vec_addr_hi;

  typedef struct packed {
    logic        fb;
    logic        im;
    logic [15:0] lo;
    logic [15:0] hi;
  } exp_t;

  localparam exp_t EXP_RST  = {1'b1, 1'b1, 16'hFFFC, 16'hFFFD};
  localparam exp_t EXP_NMI  = {1'b1, 1'b1, 16'hFFFA, 16'hFFFB};
  localparam exp_t EXP_IRQ  = {1'b1, 1'b1, 16'hFFFE, 16'hFFFF};
  localparam exp_t EXP_NONE = {1'b0, 1'b0, 16'hFFFE, 16'hFFFF};

  exp_t  sbQueue[$];
  exp_t  curExp;
  bit    curValid     = 1'b0;
  bit    sampledReset = 1'b0;
  bit    enLatched    = 1'b0;
  int    checks       = 0;
  int    failures     = 0;
  string testName     = "init";

  core_irq_ctrl dut (
    .I_clock       (I_clock),
    .I_reset       (I_reset),
    .I_enable      (I_enable),
    .I_nmi         (I_nmi),
    .I_irq         (I_irq),
    .I_irq_mask    (I_irq_mask),
    .O_force_brk   (O_force_brk),
    .O_irq_mask    (O_irq_mask),
    .O_vec_addr_lo (O_vec_addr_lo),
    .O_vec_addr_hi (O_vec_addr_hi)
  );

  always #5 I_clock = ~I_clock;

  // Compare the DUT outputs against one expected record.
  task automatic checkOutput(input string kind, input exp_t e);
    exp_t act;
    act = {O_force_brk, O_irq_mask, O_vec_addr_lo, O_vec_addr_hi};
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s/%s: got brk=%b mask=%b lo=%h hi=%h, want brk=%b mask=%b lo=%h hi=%h",
               testName, kind, act.fb, act.im, act.lo, act.hi, e.fb, e.im, e.lo, e.hi);
    end
  endtask

  // Record what the clock edge saw so the monitor knows which comparison applies.
  always @(posedge I_clock) begin
    sampledReset <= I_reset;
    enLatched    <= I_enable & ~I_reset;
  end

  // Monitor: reset edges force reset values, enable edges pop the scoreboard,
  // all other edges must leave the outputs untouched.
  always @(negedge I_clock) begin
    if (sampledReset) begin
      curExp   = EXP_RST;
      curValid = 1'b1;
      checkOutput("reset", curExp);
    end else if (enLatched) begin
      if (sbQueue.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s/unexpected_enable: got an enable with empty scoreboard, want a queued entry", testName);
      end else begin
        curExp = sbQueue.pop_front();
        checkOutput("enable", curExp);
      end
    end else if (curValid) begin
      checkOutput("hold", curExp);
    end
  end

  task automatic waitClocks(input int n);
    for (int i = 0; i < n; i++) @(negedge I_clock);
  endtask

  // One-clock enable pulse; the result appears after that clock's rising edge.
  task automatic applyStimulus(input exp_t e);
    I_enable = 1'b1;
    sbQueue.push_back(e);
    @(negedge I_clock);
    I_enable = 1'b0;
  endtask

  initial begin
    @(negedge I_clock);
    testName = "t1_reset";
    waitClocks(2);
    I_reset = 1'b0;
    applyStimulus(EXP_RST);
    applyStimulus(EXP_NONE);

    testName = "t2_irq";
    I_irq = 1'b0;
    I_irq_mask = 1'b0;
    waitClocks(3);
    applyStimulus(EXP_IRQ);
    I_irq_mask = 1'b1;
    applyStimulus(EXP_NONE);
    I_irq_mask = 1'b0;
    I_irq = 1'b1;
    waitClocks(3);
    applyStimulus(EXP_NONE);

    testName = "t3_nmi";
    I_nmi = 1'b0;
    waitClocks(1);
    I_nmi = 1'b1;
    waitClocks(10);
    applyStimulus(EXP_NMI);
    I_nmi = 1'b0;
    waitClocks(5);
    applyStimulus(EXP_NMI);
    waitClocks(3);
    applyStimulus(EXP_NONE);
    I_nmi = 1'b1;
    waitClocks(4);

    testName = "t4_nmi_over_irq";
    I_nmi = 1'b0;
    I_irq = 1'b0;
    waitClocks(1);
    I_nmi = 1'b1;
    waitClocks(5);
    applyStimulus(EXP_NMI);
    applyStimulus(EXP_IRQ);
    I_irq = 1'b1;
    waitClocks(3);
    applyStimulus(EXP_NONE);

    testName = "t5_reset_discards_nmi";
    I_nmi = 1'b0;
    waitClocks(1);
    I_nmi = 1'b1;
    waitClocks(5);
    I_reset = 1'b1;
    waitClocks(2);
    I_reset = 1'b0;
    applyStimulus(EXP_RST);
    applyStimulus(EXP_NONE);

    testName = "reset_with_enable";
    I_reset = 1'b1;
    I_enable = 1'b1;
    @(negedge I_clock);
    I_enable = 1'b0;
    I_reset = 1'b0;
    applyStimulus(EXP_RST);
    applyStimulus(EXP_NONE);

    testName = "nmi_edge_during_reset_sel";
    I_reset = 1'b1;
    waitClocks(1);
    I_reset = 1'b0;
    I_nmi = 1'b0;
    waitClocks(1);
    I_nmi = 1'b1;
    waitClocks(1);
    applyStimulus(EXP_RST);
    applyStimulus(EXP_NMI);
    applyStimulus(EXP_NONE);

    testName = "nmi_edge_same_cycle";
    I_nmi = 1'b0;
    waitClocks(1);
    I_nmi = 1'b1;
    waitClocks(1);
    applyStimulus(EXP_NMI);
    applyStimulus(EXP_NONE);

    testName = "t6_toggle_hold";
    I_irq_mask = 1'b1;
    for (int i = 0; i < 8; i++) begin
      I_irq = ~I_irq;
      @(negedge I_clock);
    end
    I_irq = 1'b1;
    applyStimulus(EXP_NONE);
    I_nmi = 1'b0;
    waitClocks(2);
    I_nmi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      I_irq = ~I_irq;
      @(negedge I_clock);
    end
    I_irq = 1'b1;
    applyStimulus(EXP_NMI);
    I_irq_mask = 1'b0;
    waitClocks(3);

    testName = "drain";
    for (int k = 0; k < 50 && sbQueue.size() != 0; k++) @(negedge I_clock);
    if (sbQueue.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: got %0d pending scoreboard entries, want 0", sbQueue.size());
    end
    @(negedge I_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
